// File: rtl/mc_controller_if.sv
// Control bus between the multicycle controller and its datapath: IR/flag inputs
// to the controller and every strobe/mux select it drives back.
interface mc_controller_if;
    logic [15:0] instruction;
    logic        alu_zero;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        IorD;
    logic        DM;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        ARS;
    logic [1:0]  MemToReg;
    logic        RegWrite;
    logic        IMS;
    logic        NI;
    logic [2:0]  ALUop;
    logic [1:0]  PCSrc;
    logic        halted;

    modport master (
        input  instruction, alu_zero,
        output PCWrite, PCWriteCond, IorD, DM, MemRead, MemWrite, IRWrite, ARS,
               MemToReg, RegWrite, IMS, NI, ALUop, PCSrc, halted
    );

    modport slave (
        output instruction, alu_zero,
        input  PCWrite, PCWriteCond, IorD, DM, MemRead, MemWrite, IRWrite, ARS,
               MemToReg, RegWrite, IMS, NI, ALUop, PCSrc, halted
    );
endinterface

// File: rtl/mc_controller.sv
// Moore FSM controller for a 16-bit multicycle processor.
// Define MC_CTRL_HALT_EN to make opcode 0011 enter a HALT state left only by rst.
module mc_controller (
    input  logic          clk,
    input  logic          rst,
    mc_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_RD, S_LOAD_WB, S_MEM_WR, S_EX_JMP, S_EX_BRZ,
        S_EX_ALU, S_WB_ALU, S_MOVETO, S_EX_IMM, S_HALT
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       dm;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       ars;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       ims;
        logic       ni;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                           ALU_OR  = 3'b011, ALU_NOT = 3'b100, ALU_PASS_BOT = 3'b101,
                           ALU_PASS_TOP = 3'b110;

    state_t     state, next_state;
    ctrl_t      ctrl;
    logic [2:0] fn_op;
    logic [3:0] opcode;
    logic [8:0] func;
    logic       fn_valid;

    assign opcode   = bus.instruction[15:12];
    assign func     = bus.instruction[8:0];
    // C-type dispatch only for a one-hot code naming a real operation (bits 0..6).
    assign fn_valid = $onehot(func) && !func[7] && !func[8];

    // Register-field and flag inputs are consumed by the datapath, not here.
    logic unused_bits;
    assign unused_bits = ^{bus.alu_zero, bus.instruction[11:9]};

    // NOTE: state is updated with <= so every flop samples pre-edge values;
    // the comb blocks below use = because they describe wires, not storage.
    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    always_comb begin
        fn_op = ALU_ADD;
        if      (func[1]) fn_op = ALU_PASS_TOP;
        else if (func[3]) fn_op = ALU_SUB;
        else if (func[4]) fn_op = ALU_AND;
        else if (func[5]) fn_op = ALU_OR;
        else if (func[6]) fn_op = ALU_NOT;
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned; without it synthesis would infer a latch.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                casez (opcode)
                    4'b0000: next_state = S_MEM_RD;
                    4'b0001: next_state = S_MEM_WR;
                    4'b0010: next_state = S_EX_JMP;
                    4'b0100: next_state = S_EX_BRZ;
                    4'b1000: if (fn_valid) next_state = func[0] ? S_MOVETO : S_EX_ALU;
                    4'b11??: next_state = S_EX_IMM;
`ifdef MC_CTRL_HALT_EN
                    4'b0011: next_state = S_HALT;
`endif
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEM_RD: next_state = S_LOAD_WB;
            S_EX_ALU: next_state = S_WB_ALU;
            S_EX_IMM: next_state = S_WB_ALU;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read = 1'b1;
                ctrl.ir_write = 1'b1;
                ctrl.ni       = 1'b1;
                ctrl.pc_write = 1'b1;
            end
            S_DECODE:  ctrl.ars = 1'b1;
            S_MEM_RD:  begin ctrl.dm = 1'b1; ctrl.mem_read = 1'b1; end
            S_LOAD_WB: begin ctrl.ars = 1'b1; ctrl.mem_to_reg = 2'b01; ctrl.reg_write = 1'b1; end
            S_MEM_WR:  begin ctrl.dm = 1'b1; ctrl.mem_write = 1'b1; end
            S_EX_JMP:  begin ctrl.pc_src = 2'b01; ctrl.pc_write = 1'b1; end
            S_EX_BRZ: begin
                ctrl.alu_op        = ALU_PASS_BOT;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = 2'b10;
            end
            S_EX_ALU:  ctrl.alu_op = fn_op;
            S_EX_IMM:  begin ctrl.ims = 1'b1; ctrl.alu_op = {1'b0, opcode[1:0]}; end
            S_WB_ALU:  begin ctrl.ars = 1'b1; ctrl.mem_to_reg = 2'b10; ctrl.reg_write = 1'b1; end
            S_MOVETO:  ctrl.reg_write = 1'b1;
            default:   ctrl = '0;
        endcase
        // Reset blanks every strobe immediately so an interrupted instruction writes nothing.
        if (rst) ctrl = '0;
    end

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.ior_d;
    assign bus.DM          = ctrl.dm;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.ARS         = ctrl.ars;
    assign bus.MemToReg    = ctrl.mem_to_reg;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.IMS         = ctrl.ims;
    assign bus.NI          = ctrl.ni;
    assign bus.ALUop       = ctrl.alu_op;
    assign bus.PCSrc       = ctrl.pc_src;

`ifdef MC_CTRL_HALT_EN
    assign bus.halted = !rst && (state == S_HALT);
`else
    assign bus.halted = 1'b0;
`endif
endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: a per-instruction model pushes expected
// control vectors per cycle; a negedge monitor pops and compares them.
module tb_mc_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_controller_if bus ();
    mc_controller dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic       pc_write, pc_write_cond, ior_d, dm, mem_read, mem_write, ir_write, ars;
        logic [1:0] mem_to_reg;
        logic       reg_write, ims, ni;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       halted;
    } ctl_t;

    typedef struct packed {
        ctl_t        c;
        logic [15:0] instr;
        logic [7:0]  cyc;
    } exp_t;

    exp_t exp_q[$];
    ctl_t seq[$];
    bit   seq_halts;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Control vector a state must show, written straight from the state descriptions.
    function automatic ctl_t ctl_of(input string s, input logic [2:0] op);
        ctl_t c;
        c = '0;
        case (s)
            "FETCH":   begin c.mem_read = 1; c.ir_write = 1; c.ni = 1; c.pc_write = 1; end
            "DECODE":  c.ars = 1;
            "MEM_RD":  begin c.dm = 1; c.mem_read = 1; end
            "LOAD_WB": begin c.ars = 1; c.mem_to_reg = 2'b01; c.reg_write = 1; end
            "MEM_WR":  begin c.dm = 1; c.mem_write = 1; end
            "EX_JMP":  begin c.pc_src = 2'b01; c.pc_write = 1; end
            "EX_BRZ":  begin c.alu_op = 3'b101; c.pc_write_cond = 1; c.pc_src = 2'b10; end
            "EX_ALU":  c.alu_op = op;
            "EX_IMM":  begin c.ims = 1; c.alu_op = op; end
            "WB_ALU":  begin c.ars = 1; c.mem_to_reg = 2'b10; c.reg_write = 1; end
            "MOVETO":  c.reg_write = 1;
            "HALT":    c.halted = 1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    // Whole-instruction reference: the list of per-cycle control vectors.
    task automatic model_seq(input logic [15:0] ins);
        logic [3:0] op;
        logic [8:0] fn;
        op = ins[15:12];
        fn = ins[8:0];
        seq.delete();
        seq_halts = 0;
        seq.push_back(ctl_of("FETCH", 0));
        seq.push_back(ctl_of("DECODE", 0));
        case (op)
            4'd0: begin seq.push_back(ctl_of("MEM_RD", 0)); seq.push_back(ctl_of("LOAD_WB", 0)); end
            4'd1: seq.push_back(ctl_of("MEM_WR", 0));
            4'd2: seq.push_back(ctl_of("EX_JMP", 0));
            4'd4: seq.push_back(ctl_of("EX_BRZ", 0));
            4'd8: begin
                if ($countones(fn) == 1) begin
                    if (fn[0]) seq.push_back(ctl_of("MOVETO", 0));
                    for (int i = 1; i <= 6; i++) begin
                        if (fn[i]) begin
                            case (i)
                                1: seq.push_back(ctl_of("EX_ALU", 3'd6));
                                2: seq.push_back(ctl_of("EX_ALU", 3'd0));
                                3: seq.push_back(ctl_of("EX_ALU", 3'd1));
                                4: seq.push_back(ctl_of("EX_ALU", 3'd2));
                                5: seq.push_back(ctl_of("EX_ALU", 3'd3));
                                default: seq.push_back(ctl_of("EX_ALU", 3'd4));
                            endcase
                            seq.push_back(ctl_of("WB_ALU", 0));
                        end
                    end
                end
            end
            4'd12, 4'd13, 4'd14, 4'd15: begin
                seq.push_back(ctl_of("EX_IMM", 3'(op - 4'd12)));
                seq.push_back(ctl_of("WB_ALU", 0));
            end
`ifdef MC_CTRL_HALT_EN
            4'd3: begin
                seq_halts = 1;
                for (int i = 0; i < 10; i++) seq.push_back(ctl_of("HALT", 0));
            end
`endif
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction; cut >= 0 asserts rst in place of cycle number cut.
    task automatic run(input logic [15:0] ins, input int cut);
        int  n;
        bit  do_rst;
        model_seq(ins);
        n      = seq.size();
        do_rst = seq_halts;
        if (cut >= 0 && cut < n) begin
            n      = cut;
            do_rst = 1;
        end
        bus.instruction = ins;
        for (int i = 0; i < n; i++) exp_q.push_back('{c: seq[i], instr: ins, cyc: 8'(i)});
        repeat (n) tick();
        if (do_rst) begin
            rst = 1'b1;
            exp_q.push_back('{c: ctl_t'('0), instr: ins, cyc: 8'(n)});
            tick();
            rst = 1'b0;
        end
    endtask

    ctl_t mon_a;
    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.DM, bus.MemRead,
                     bus.MemWrite, bus.IRWrite, bus.ARS, bus.MemToReg, bus.RegWrite,
                     bus.IMS, bus.NI, bus.ALUop, bus.PCSrc, bus.halted};
            check($sformatf("ctl instr=%h cyc=%0d rst=%0b", mon_e.instr, mon_e.cyc, rst),
                  32'(mon_a), 32'(mon_e.c));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [15:0] ins;
        int          cut;
        rst             = 1'b1;
        bus.instruction = 16'h0000;
        bus.alu_zero    = 1'b0;
        tick();
        exp_q.push_back('{c: ctl_t'('0), instr: 16'h0000, cyc: 8'd0});
        tick();
        rst = 1'b0;

        run(16'h0ABC, -1);
        bus.alu_zero = 1'b1;
        run(16'h4123, -1);
        bus.alu_zero = 1'b0;
        run(16'h4123, -1);
        run(16'h8604, -1);
        run(16'h8201, -1);
        run(16'h8003, -1);
        run(16'h1000, -1);
        run(16'h2345, -1);
        run(16'h8002, -1);
        run(16'h8080, -1);
        run(16'hC7FF, 3);
        run(16'hD001, -1);
        run(16'h3000, -1);
        run(16'h0ABC, 2);

        repeat (60) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 1) == 1)
                ins = {4'h8, 3'($urandom), 9'(1 << $urandom_range(0, 8))};
            cut = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4)) : -1;
            bus.alu_zero = 1'($urandom);
            run(ins, cut);
        end

        tick();
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
